// File: rtl/dual_func_pc_pkg.sv
// Shared constants for the dual-function program counter: mode encodings and default width.
package dual_func_pc_pkg;

  localparam int PC_WIDTH = 32;

  typedef enum logic {
    MODE_REL = 1'b0,
    MODE_ABS = 1'b1
  } mode_e;

endpackage

// File: rtl/dual_func_pc_next_logic.sv
// Combinational next-PC selection: relative add (modulo 2^WIDTH) or absolute load.
module pc_next_logic
  import dual_func_pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] datain,
  input  logic             mode,
  output logic [WIDTH-1:0] next_pc
);

  logic [WIDTH-1:0] rel_pc;

  // Carry out of the WIDTH-bit sum is dropped, so negative offsets wrap as two's complement.
  assign rel_pc  = pc + datain;
  assign next_pc = (mode == MODE_ABS) ? datain : rel_pc;

endmodule

// File: rtl/dual_func_pc.sv
// Dual-function program counter: relative/absolute load with enable and sync reset.
// Optional build macro DUAL_FUNC_PC_ALIGN_EN clears bits [1:0] of every loaded value.
module dual_func_pc
  import dual_func_pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;

  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] v);
`ifdef DUAL_FUNC_PC_ALIGN_EN
    return v & ~{{(WIDTH-2){1'b0}}, 2'b11};
`else
    return v;
`endif
  endfunction

  pc_next_logic #(
    .WIDTH(WIDTH)
  ) u_next (
    .pc     (pc),
    .datain (datain),
    .mode   (mode),
    .next_pc(next_pc)
  );

  // Reset outranks enable; the reset value goes through the same alignment as any load.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc <= align(RESET_VAL);
    end else if (enable) begin
      pc <= align(next_pc);
    end
  end

  assign dataout = pc;

endmodule

// File: tb/tb_dual_func_pc.sv
// Self-checking bench for dual_func_pc: directed literal checks plus randomized traffic vs a behavioural model.
module tb_dual_func_pc;

  localparam int          W     = 32;
  localparam logic [31:0] RVAL  = 32'h0;
`ifdef DUAL_FUNC_PC_ALIGN_EN
  localparam logic [31:0] LIT3  = 32'h0;
`else
  localparam logic [31:0] LIT3  = 32'h3;
`endif

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  datain = '0;
  logic [W-1:0]  dataout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] model_pc = '0;
  bit           model_ok = 1'b0;

  dual_func_pc #(
    .WIDTH    (W),
    .RESET_VAL(RVAL)
  ) dut (
    .CLK    (CLK),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .datain (datain),
    .dataout(dataout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] al(input logic [31:0] v);
`ifdef DUAL_FUNC_PC_ALIGN_EN
    return v & 32'hFFFF_FFFC;
`else
    return v;
`endif
  endfunction

  // Behavioural model: the PC as a plain number following the load rules.
  always @(posedge CLK) begin
    if (reset) begin
      model_pc <= al(RVAL);
      model_ok <= 1'b1;
    end else if (enable) begin
      if (mode) model_pc <= al(datain);
      else      model_pc <= al(32'(model_pc + datain));
    end
  end

  // Continuous comparison once the model has seen a reset edge.
  always @(negedge CLK) begin
    if (model_ok) begin
      n_cmp++;
      if (dataout !== model_pc) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t dataout=%h expected=%h", $time, dataout, model_pc);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic m, input logic [31:0] d);
    reset  = r;
    enable = e;
    mode   = m;
    datain = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic lit(input string name, input logic [31:0] want);
    n_cmp++;
    if (dataout !== want) begin
      n_bad++;
      $display("FAIL %s dataout=%h expected=%h", name, dataout, want);
    end
  endtask

  initial begin
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 32'h0);          lit("reset_state", 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF); lit("hold_after_reset", 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h4);          lit("rel_plus4_a", 32'h4);
    drive(1'b0, 1'b1, 1'b0, 32'h4);          lit("rel_plus4_b", 32'h8);
    drive(1'b0, 1'b1, 1'b1, 32'h3);          lit("abs_load3", LIT3);
    drive(1'b0, 1'b0, 1'b0, 32'h77);         lit("hold_rel_mode", LIT3);
    drive(1'b0, 1'b0, 1'b1, 32'h99);         lit("hold_abs_mode", LIT3);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);  lit("abs_near_top", 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 1'b0, 32'h8);          lit("wrap_add", 32'h0000_0004);
    drive(1'b0, 1'b1, 1'b1, 32'h100);        lit("abs_0x100", 32'h100);
    drive(1'b1, 1'b1, 1'b1, 32'h55);         lit("reset_priority", 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h10);         lit("first_after_reset", 32'h10);
    drive(1'b0, 1'b1, 1'b1, 32'h20);         lit("abs_0x20", 32'h20);
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);  lit("neg_offset", 32'h1C);

    for (int i = 0; i < 3000; i++) begin
      logic        r, e, m;
      logic [31:0] d;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 64));
        2:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        default: d = 32'($urandom_range(0, 15)) << 2;
      endcase
      drive(r, e, m, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_func_pc.md
DUAL_FUNC_PC -- requirements
Module: dual_func_pc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of datain, dataout and the internal PC register.
REQ-002 Parameter RESET_VAL, default 0, SHALL set the PC value loaded on reset.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: 1 = PC updates this edge; 0 = PC holds.
REQ-006 Port mode, input, 1 bit: 0 = relative (PC + datain); 1 = absolute (PC = datain).
REQ-007 Port datain, input, WIDTH bits: offset in relative mode, target address in absolute mode.
REQ-008 Port dataout, output, WIDTH bits: current PC, driven directly from the register with no combinational path from inputs.

Function
REQ-009 On a rising CLK edge with reset=0 and enable=1, mode=0 SHALL load PC + datain.
REQ-010 On a rising CLK edge with reset=0 and enable=1, mode=1 SHALL load datain.
REQ-011 With reset=0 and enable=0, PC SHALL hold regardless of mode and datain.
REQ-012 Latency SHALL be one cycle: dataout reflects the update immediately after the edge that sampled the inputs.
REQ-013 The addition SHALL be unsigned modulo 2^WIDTH; carry out SHALL be discarded (e.g. 0xFFFFFFFC + 8 = 0x00000004).
REQ-014 datain SHALL be treated as unsigned; negative offsets SHALL be expressed as two's complement, which wraps correctly under REQ-013.
REQ-015 If mode or datain is X/Z while enable=1, PC content is don't-care for that cycle, but the block SHALL recover on the next valid load.

Reset
REQ-016 reset=1 at a rising edge SHALL load RESET_VAL into PC, overriding enable, mode and datain.
REQ-017 Reset asserted mid-operation SHALL take effect at the next edge; the first update after deassertion SHALL start from RESET_VAL.
REQ-018 Before the first reset edge, dataout is undefined.

Configuration
REQ-019 Macro DUAL_FUNC_PC_ALIGN_EN, when defined, SHALL force bits [1:0] of every value loaded into PC, including RESET_VAL, to 0 (word alignment).
REQ-020 Without DUAL_FUNC_PC_ALIGN_EN, all WIDTH bits SHALL be loaded unmodified.

Structure
REQ-021 A shared package dual_func_pc_pkg SHALL hold the mode encodings MODE_REL=0 and MODE_ABS=1 and the default width constant PC_WIDTH=32.
REQ-022 Next-PC selection and the adder SHALL be a combinational sub-module pc_next_logic, with inputs pc, datain and mode and output next_pc.
REQ-023 The top level SHALL contain only the register, reset/enable priority and the alignment masking.

Verification
REQ-024 Assert reset for 1 edge, then hold enable=0 for 3 edges -> dataout=0 throughout.
REQ-025 From PC=0, enable=1, mode=0, datain=4 for 1 edge -> dataout=4; a 2nd edge -> 8.
REQ-026 From PC=8, enable=1, mode=1, datain=3 -> dataout=3 (0 with DUAL_FUNC_PC_ALIGN_EN); hold enable=0 -> stays.
REQ-027 Load PC=0xFFFFFFFC (mode=1), then mode=0, datain=8 -> dataout=0x00000004 (wrap).
REQ-028 Set PC=0x100, then at one edge drive reset=1, enable=1, mode=1, datain=0x55 -> dataout=RESET_VAL (0).
REQ-029 From PC=0x20, mode=0, datain=0xFFFFFFFC -> dataout=0x1C (negative offset).
